// File: rtl/bypass_regfile.sv
// bypass_regfile: register file with an in-flight writeback pipeline and an
// operand bypass network. Entries enter stage 0 on issue, advance one stage per
// cycle and commit to the register file from stage DEPTH-1. Late data can be
// attached at stage FILL_STAGE. Read ports return the youngest in-flight value
// or the register file contents, and request a stall when the value is missing.
// Optional macro: BYPASS_REGFILE_BYPASS_EN enables forwarding. When it is left
// undefined, any matching in-flight writer stalls the read port and the read
// data always comes from the register file.
module bypass_regfile #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int DEPTH      = 3,
    parameter int NRD        = 2,
    parameter int FILL_STAGE = 1,
    localparam int AW        = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_val,
    input  logic                iss_wen,
    input  logic [AW-1:0]       iss_waddr,
    input  logic [XLEN-1:0]     iss_data,
    input  logic                iss_dval,
    input  logic                kill_s0,
    input  logic                fill_val,
    input  logic [XLEN-1:0]     fill_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_stall,
    output logic                wb_val,
    output logic [AW-1:0]       wb_addr,
    output logic [XLEN-1:0]     wb_data,
    output logic                err
);

    logic [DEPTH-1:0]           val_q, val_d;
    logic [DEPTH-1:0]           wen_q, wen_d;
    logic [DEPTH-1:0]           dval_q, dval_d;
    logic [DEPTH-1:0][AW-1:0]   waddr_q, waddr_d;
    logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;
    logic [NREGS-1:0][XLEN-1:0] rf_q;
    logic                       err_q;
    logic                       fill_hit;
    logic                       commit;

    assign fill_hit = fill_val & val_q[FILL_STAGE] & wen_q[FILL_STAGE] & ~dval_q[FILL_STAGE];
    assign commit   = val_q[DEPTH-1] & wen_q[DEPTH-1] & (waddr_q[DEPTH-1] != '0);

    // Shift chain next state: issue into stage 0, squash on kill, attach late data.
    always_comb begin
        val_d[0]   = iss_val;
        wen_d[0]   = iss_wen;
        waddr_d[0] = iss_waddr;
        data_d[0]  = iss_data;
        dval_d[0]  = iss_dval;
        for (int k = 1; k < DEPTH; k++) begin
            val_d[k]   = val_q[k-1];
            wen_d[k]   = wen_q[k-1];
            waddr_d[k] = waddr_q[k-1];
            data_d[k]  = data_q[k-1];
            dval_d[k]  = dval_q[k-1];
        end
        val_d[1] = val_q[0] & ~kill_s0;
        if (fill_hit) begin
            data_d[FILL_STAGE+1] = fill_data;
            dval_d[FILL_STAGE+1] = 1'b1;
        end
    end

    // Pipeline registers advance unconditionally every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q   <= '0;
            wen_q   <= '0;
            dval_q  <= '0;
            waddr_q <= '0;
            data_q  <= '0;
        end else begin
            val_q   <= val_d;
            wen_q   <= wen_d;
            dval_q  <= dval_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
        end
    end

    // Register file write from the last stage, plus the sticky missing-data flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q  <= '0;
            err_q <= 1'b0;
        end else if (commit) begin
            rf_q[waddr_q[DEPTH-1]] <= data_q[DEPTH-1];
            if (!dval_q[DEPTH-1]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wb_val  = commit;
    assign wb_addr = waddr_q[DEPTH-1];
    assign wb_data = data_q[DEPTH-1];
    assign err     = err_q;

    // Read ports: scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        rd_data  = '0;
        rd_stall = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = rf_q[rd_addr[i*AW +: AW]];
            for (int k = DEPTH-1; k >= 0; k--) begin
                if (val_q[k] && wen_q[k] && (rd_addr[i*AW +: AW] != '0) &&
                    (waddr_q[k] == rd_addr[i*AW +: AW])) begin
`ifdef BYPASS_REGFILE_BYPASS_EN
                    rd_data[i*XLEN +: XLEN] = data_q[k];
                    rd_stall[i]             = ~dval_q[k];
`else
                    rd_stall[i]             = 1'b1;
`endif
                end
            end
        end
    end

endmodule
